// File: rtl/mdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdc_pkg: digit width, per-radix digit maxima, mode/direction codes.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mdc_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  HEX_MAX = 4'd15;

    typedef enum logic {
        MODE_BCD = 1'b0,
        MODE_HEX = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [3:0] digit_max(input logic mode);
        return (mode == MODE_HEX) ? HEX_MAX : BCD_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdc_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdc_digit: one 4-bit up/down digit, BCD or hex, with terminal flag.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mdc_digit
    import mdc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic                 mode,
    input  logic                 direction,
    input  logic                 load,
    input  logic [DIGIT_W-1:0]   load_digit,
    output logic [DIGIT_W-1:0]   digit,
    output logic                 terminal
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;
    logic [DIGIT_W-1:0] w_max;

    assign w_max = digit_max(mode);

    // ">=" makes out-of-range BCD values (10-15) terminal when counting up.
    assign terminal = (direction == DIR_DOWN) ? (digit_q == '0) : (digit_q >= w_max);

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (step) begin
            if (direction == DIR_UP) begin
                digit_d = terminal ? '0 : digit_q + 4'd1;
            end else if (digit_q == '0) begin
                digit_d = w_max;
            end else if (digit_q > w_max) begin
                digit_d = w_max;
            end else begin
                digit_d = digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule
`default_nettype wire

// File: rtl/multi_digit_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_digit_updown_counter: N-digit cascaded BCD/hex up/down counter |
// | with registered wrap pulse. Parallel load enabled by MDC_LOAD_EN.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multi_digit_updown_counter
    import mdc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      mode,
    input  logic                      direction,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_value,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      carry_out
);

    logic                      w_load;
    logic [DIGIT_W*DIGITS-1:0] w_load_value;
    logic [DIGITS-1:0]         w_term;
    logic [DIGITS:0]           w_chain;
    logic                      carry_q;
    logic                      carry_d;

`ifdef MDC_LOAD_EN
    assign w_load       = load;
    assign w_load_value = load_value;
`else
    // Pins kept for compatibility; tying the digit load to zero removes the mux.
    logic w_unused_load;
    assign w_unused_load = ^{load, load_value};
    assign w_load        = 1'b0;
    assign w_load_value  = '0;
`endif

    assign w_chain[0] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        mdc_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .step       (enable & w_chain[gi]),
            .mode       (mode),
            .direction  (direction),
            .load       (w_load),
            .load_digit (w_load_value[gi*DIGIT_W +: DIGIT_W]),
            .digit      (count[gi*DIGIT_W +: DIGIT_W]),
            .terminal   (w_term[gi])
        );
        assign w_chain[gi+1] = w_chain[gi] & w_term[gi];
    end

    // All digits terminal means this enabled edge wraps the whole counter.
    assign carry_d = w_load ? 1'b0 : (enable & w_chain[DIGITS]);

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_updown_counter.sv
`default_nettype none
// Bench for multi_digit_updown_counter (DIGITS=4): reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_multi_digit_updown_counter;

`ifdef MDC_LOAD_EN
    localparam bit LOAD_ON = 1'b1;
`else
    localparam bit LOAD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, mode, direction, load;
    logic [15:0] load_value;
    logic [15:0] count;
    logic        carry_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_count;
    logic        m_carry;
    bit          m_valid = 1'b0;

    multi_digit_updown_counter #(.DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .direction  (direction),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .carry_out  (carry_out)
    );

    always #5 clk = ~clk;

    // Next value and wrap flag for one enabled step.
    function automatic logic [16:0] model_step(input logic [15:0] c, input logic md, input logic dr);
        logic [15:0] n;
        int          mx;
        bit          prop;
        int          d;
        if (md) begin
            if (!dr) return {c == 16'hFFFF, c + 16'd1};
            return {c == 16'h0000, c - 16'd1};
        end
        // BCD: a digit moves only if every lower digit is at its end point.
        n = c;
        mx = 9;
        prop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (prop) begin
                d = int'(c[4*i +: 4]);
                if (!dr) begin
                    prop = (d >= mx);
                    n[4*i +: 4] = prop ? 4'd0 : 4'(d + 1);
                end else begin
                    prop = (d == 0);
                    n[4*i +: 4] = (d == 0 || d > mx) ? 4'd9 : 4'(d - 1);
                end
            end
        end
        return {prop, n};
    endfunction

    always @(posedge clk) begin
        logic [16:0] r;
        if (reset) begin
            m_count <= 16'h0;
            m_carry <= 1'b0;
            m_valid <= 1'b1;
        end else if (LOAD_ON && load) begin
            m_count <= load_value;
            m_carry <= 1'b0;
        end else if (enable) begin
            r = model_step(m_count, mode, direction);
            m_count <= r[15:0];
            m_carry <= r[16];
        end else begin
            m_carry <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (count !== m_count) begin
                n_bad++;
                $display("FAIL model_count t=%0t: got %h expected %h", $time, count, m_count);
            end
            n_cmp++;
            if (carry_out !== m_carry) begin
                n_bad++;
                $display("FAIL model_carry t=%0t: got %b expected %b", $time, carry_out, m_carry);
            end
        end
    end

    task automatic cyc(input logic r, input logic en, input logic md, input logic dr,
                       input logic ld, input logic [15:0] lv);
        reset = r; enable = en; mode = md; direction = dr; load = ld; load_value = lv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [15:0] ec, input logic ecar);
        n_cmp++;
        if (count !== ec || carry_out !== ecar) begin
            n_bad++;
            $display("FAIL %s: got count=%h carry=%b expected count=%h carry=%b",
                     nm, count, carry_out, ec, ecar);
        end
    endtask

    // Reset, then reach v by loading (if available) or by hex counting.
    task automatic preset(input logic [15:0] v);
        cyc(1, 0, 0, 0, 0, 16'h0);
        if (LOAD_ON) begin
            cyc(0, 0, 0, 0, 1, v);
        end else begin
            repeat (int'(v)) cyc(0, 1, 1, 0, 0, 16'h0);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 16'h0);
        chk("reset_state", 16'h0000, 1'b0);

        repeat (7) cyc(0, 1, 1, 0, 0, 16'h0);
        cyc(0, 1, 0, 1, 0, 16'h0);
        cyc(1, 1, 1, 0, 1, 16'h1234);
        chk("reset_after_activity", 16'h0000, 1'b0);

        preset(16'h0099);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("bcd_up_chain", 16'h0100, 1'b0);

        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 1, 0, 16'h0);
        chk("bcd_down_wrap", 16'h9999, 1'b1);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("bcd_up_wrap", 16'h0000, 1'b1);
        cyc(0, 0, 0, 0, 0, 16'h0);
        chk("carry_one_cycle", 16'h0000, 1'b0);

        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 1, 1, 0, 16'h0);
        chk("hex_down_wrap", 16'hFFFF, 1'b1);
        cyc(0, 1, 1, 1, 0, 16'h0);
        chk("hex_down_next", 16'hFFFE, 1'b0);

        preset(16'h00AF);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("mode_switch_up", 16'h0100, 1'b0);

        preset(16'h0A00);
        cyc(0, 1, 0, 1, 0, 16'h0);
        chk("bcd_down_out_of_range", 16'h0999, 1'b0);

        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 1, 16'h0A59);
        chk("load_or_count", LOAD_ON ? 16'h0A59 : 16'h0001, 1'b0);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("after_load_step", LOAD_ON ? 16'h0A60 : 16'h0002, 1'b0);

        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 1, 0, 16'h0);
        cyc(0, 1, 0, 0, 1, 16'h9999);
        if (LOAD_ON) chk("load_clears_carry", 16'h9999, 1'b0);
        else         chk("load_ignored_wrap", 16'h0000, 1'b1);

        preset(16'h1234);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 0, 16'h0);
            chk("hold", 16'h1234, 1'b0);
        end
        cyc(1, 1, 0, 0, 0, 16'h0);
        chk("reset_over_enable", 16'h0000, 1'b0);

        for (int k = 0; k < 300; k++) begin
            cyc(1'(k == 150), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_digit_updown_counter.md
# multi_digit_updown_counter

Parametrised N-digit cascaded up/down counter with per-cycle selectable BCD or hexadecimal radix. It is the next generation of the single-digit decade counter and replaces hand-chained digit instances in the display-counter datapath. A single wide `count` bus drives the seven-segment multiplexer, and a registered wrap pulse supports cascading or event logging.

## Interface
- `DIGITS`, 4: number of 4-bit digits; legal range 1–8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  count step request, sampled every rising edge.
- `mode`  in  1  radix: 0 = BCD (digits 0–9), 1 = hex (digits 0–F).
- `direction`  in  1  0 = up, 1 = down.
- `load`  in  1  synchronous parallel load (active only with `MDC_LOAD_EN`).
- `load_value`  in  4*DIGITS  value for parallel load; digit i is at bits [4i+3:4i].
- `count`  out  4*DIGITS  current count; digit 0 is least significant.
- `carry_out`  out  1  registered one-cycle pulse on whole-counter wrap.

## Operation
- Priority, per edge: `reset` > `load` > `enable` > hold.
- Digit max value: 9 when `mode`=0, 15 when `mode`=1.
- Terminal digit:
  - up: digit ≥ max. In BCD, values 10–15 count as terminal.
  - down: digit == 0.
- Digit i steps on an edge when `enable`=1 and digits 0..i-1 are all terminal. Digit 0 steps on every enabled edge.
- Up step: a terminal digit goes to 0; otherwise it goes to digit+1.
- Down step: digit 0 goes to max; a BCD digit holding 10–15 goes to 9; otherwise it goes to digit-1.
- Wrap: `carry_out` is set to (`enable` AND all digits terminal) on each edge, so it is high for exactly the cycle in which `count` shows the wrapped value.
- `carry_out` is cleared on reset and on load.
- `mode` and `direction` may change on any cycle. They take effect on the next enabled edge and leave no extra state behind.
- Out-of-range BCD digits are never produced by counting. They can only enter via load or via a switch from hex mode, and the rules above normalise them.

## Timing
- Reset values: `count` = 0, `carry_out` = 0.
- Latency: one edge from `enable`/`load` sampled high to the updated `count`. `carry_out` updates on that same edge.
- No combinational path from any input to any output; all outputs come straight from registers.
- Reset asserted mid-count clears everything on the next edge, regardless of `enable` or `load`.
- With `enable` held high continuously, the counter advances one step per cycle with no bubbles.

## Configuration
- `MDC_LOAD_EN` defined: `load`/`load_value` are functional. When `load`=1, `count` <= `load_value` verbatim (no clamping) and `carry_out` <= 0.
- `MDC_LOAD_EN` undefined: the ports remain for pin compatibility but are ignored, no load mux is synthesised, and `load` has no effect on any output.

## Structure
- Package `mdc_pkg` holds:
  - `DIGIT_W` = 4, `BCD_MAX` = 4'd9, `HEX_MAX` = 4'd15;
  - mode encodings `MODE_BCD`/`MODE_HEX`;
  - direction encodings `DIR_UP`/`DIR_DOWN`.
- Sub-module `mdc_digit`: one digit register with inputs `step`, `mode`, `direction`, `load`, `load_digit` and outputs `digit`, `terminal`. The top instantiates `DIGITS` copies in a generate loop, forms each digit's step as `enable` AND the AND-chain of lower `terminal` outputs, and owns the `carry_out` register.

## Test plan
- Reset: run arbitrary activity, then assert `reset` for one edge → `count` = 0x0000, `carry_out` = 0 on the following cycle.
- BCD up carry chain: start at 0x0099 with `mode`=0, `direction`=0, one enable → 0x0100, `carry_out` = 0. From 0x9999, one enable → 0x0000, `carry_out` = 1 for one cycle only.
- Hex down wrap: start at 0x0000 with `mode`=1, `direction`=1, one enable → 0xFFFF, `carry_out` = 1. Next enable → 0xFFFE, `carry_out` = 0.
- Mode switch: count at 0x00AF in hex, switch to BCD up, one enable → 0x0100.
- Load (macro on): `load`=1, `enable`=1, `load_value` = 0x0A59 → `count` = 0x0A59, `carry_out` = 0. Then BCD up enable → 0x0A60. Macro off: the same stimulus only counts, giving 0x0001 from 0x0000.
- Hold and reset mid-operation: `enable`=0 for 5 cycles at 0x1234 → unchanged. Then `reset`=1 together with `enable`=1 → 0x0000.
